// File: rtl/out_ctl_if.sv
// AXI-Stream style output channel carrying accumulator words downstream.
// master drives valid/data/last; slave returns ready.
interface out_ctl_if #(
   parameter int DW = 32
);
   logic          m_tvalid;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic          m_tready;

   modport master (output m_tvalid, m_tdata, m_tlast, input m_tready);
   modport slave  (input m_tvalid, m_tdata, m_tlast, output m_tready);
endinterface

// File: rtl/out_ctl.sv
// Output controller: copies N_OUT accumulators per k_fin into a FIFO and streams them out; err only with OUT_CTL_ERR_EN.
// Latency: k_fin at T -> out_re T+1, first m_tvalid T+3, outrf high T+N_OUT+3 (m_tready=1).
// Backpressure: reads stall once FIFO occupancy plus the in-flight read reaches DEPTH; out_busy stays high.

module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   // A pop frees the slot in the same cycle, so a push at full is accepted alongside it.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign dout    = mem[rp];
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= nxt(wp);
         if (do_pop)  rp <= nxt(rp);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

module out_ctl #(
   parameter int N_OUT = 8,
   parameter int N_BLK = 4,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_init,
   input  logic                       k_fin,
   output logic                       out_busy,
   output logic                       outrf,
   output logic                       out_re,
   output logic [$clog2(N_OUT)-1:0]   out_a,
   input  logic [DW-1:0]              acc_d,
   out_ctl_if.master                  m_axis,
   output logic                       err
);
   localparam int AW = $clog2(N_OUT);
   localparam int BW = (N_BLK > 1) ? $clog2(N_BLK) : 1;
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {IDLE, RD} state_t;
   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } word_t;

   state_t        state;
   logic [AW-1:0] wc;
   logic [BW-1:0] blk;
   logic          rd_pend, rd_tag, last_rd;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occ;
   logic          fifo_empty, pop;
   word_t         push_w, head_w;

   // Reserve a FIFO slot for every read in flight so a capture never overflows.
   assign occ      = {1'b0, fifo_count} + (CW+1)'(rd_pend);
   assign out_re   = (state == RD) && (occ < (CW+1)'(DEPTH));
   assign last_rd  = out_re && (wc == AW'(N_OUT-1));
   assign out_a    = wc;
   assign out_busy = k_fin || (state == RD) || rd_pend;
   assign outrf    = (state == IDLE) && !rd_pend && fifo_empty && !k_fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wc      <= '0;
         blk     <= '0;
         rd_pend <= 1'b0;
         rd_tag  <= 1'b0;
      end else begin
         rd_pend <= out_re;
         rd_tag  <= last_rd && (blk == BW'(N_BLK-1));
         case (state)
            IDLE: if (k_fin) begin
               state <= RD;
               wc    <= '0;
            end
            RD: if (out_re) begin
               wc <= wc + AW'(1);
               if (last_rd) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (s_init)       blk <= '0;
         else if (last_rd) blk <= (blk == BW'(N_BLK-1)) ? '0 : blk + BW'(1);
      end
   end

   assign push_w = '{last: rd_tag, data: acc_d};
   assign pop    = m_axis.m_tvalid && m_axis.m_tready;

   fifo #(.W($bits(word_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_pend),
      .din   (push_w),
      .pop   (pop),
      .dout  (head_w),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign m_axis.m_tvalid = !fifo_empty;
   assign m_axis.m_tdata  = head_w.data;
   assign m_axis.m_tlast  = !fifo_empty && head_w.last;

`ifdef OUT_CTL_ERR_EN
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if ((k_fin && ((state != IDLE) || rd_pend)) || (s_init && !outrf))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_out_ctl.sv
module tb_out_ctl;
   localparam int N_OUT = 8;
   localparam int N_BLK = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
`ifdef OUT_CTL_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, s_init, k_fin;
   logic          out_busy, outrf, out_re, err;
   logic [2:0]    out_a;
   logic [DW-1:0] acc_d;
   logic [DW-1:0] acc_base;
   logic [DW:0]   got_q [$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            nre;

   out_ctl_if #(.DW(DW)) ax ();

   out_ctl #(.N_OUT(N_OUT), .N_BLK(N_BLK), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_init   (s_init),
      .k_fin    (k_fin),
      .out_busy (out_busy),
      .outrf    (outrf),
      .out_re   (out_re),
      .out_a    (out_a),
      .acc_d    (acc_d),
      .m_axis   (ax),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Accumulator array: read data appears the cycle after the address.
   always @(posedge clk) acc_d <= acc_base + DW'(out_a);

   always @(posedge clk)
      if (!rst && ax.m_tvalid && ax.m_tready)
         got_q.push_back({ax.m_tlast, ax.m_tdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rs, input logic kf, input logic si, input logic rdy);
      @(posedge clk);
      #1;
      rst         = rs;
      k_fin       = kf;
      s_init      = si;
      ax.m_tready = rdy;
      @(negedge clk);
   endtask

   task automatic chk_stream(input string tag, input int n, input logic [DW-1:0] base);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < got_q.size()) begin
            chk({tag, "_data"}, 64'(got_q[i][DW-1:0]), 64'(base + DW'(i)));
            chk({tag, "_last"}, 64'(got_q[i][DW]), 64'(0));
         end
      end
   endtask

   initial begin
      rst = 1'b1; k_fin = 1'b0; s_init = 1'b0; ax.m_tready = 1'b0; acc_base = '0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_busy",  64'(out_busy),     64'(0));
      chk("rst_outrf", 64'(outrf),        64'(1));
      chk("rst_re",    64'(out_re),       64'(0));
      chk("rst_a",     64'(out_a),        64'(0));
      chk("rst_vld",   64'(ax.m_tvalid),  64'(0));
      chk("rst_last",  64'(ax.m_tlast),   64'(0));
      chk("rst_err",   64'(err),          64'(0));
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // Single kernel, cycle-exact latency profile relative to k_fin (c=0).
      acc_base = 32'h100;
      for (int c = 0; c <= 12; c++) begin
         step(0, c == 0, 0, 1);
         chk("t1_busy",  64'(out_busy), 64'(c <= 9));
         chk("t1_outrf", 64'(outrf),    64'(c >= 11));
         chk("t1_re",    64'(out_re),   64'(c >= 1 && c <= 8));
         if (c >= 1 && c <= 8) chk("t1_a", 64'(out_a), 64'(c - 1));
         chk("t1_vld", 64'(ax.m_tvalid), 64'(c >= 3 && c <= 10));
         if (c >= 3 && c <= 10) begin
            chk("t1_data", 64'(ax.m_tdata), 64'(32'h100 + c - 3));
            chk("t1_last", 64'(ax.m_tlast), 64'(0));
         end
      end

      // Two stripes of N_BLK kernels after one s_init: tlast on words 31 and 63 only.
      got_q.delete();
      step(0, 0, 1, 1);
      for (int c = 0; c < 8 * 12 + 4; c++) begin
         if (c % 12 == 0 && c < 96) acc_base = 32'h200 + DW'((c / 12) * 16);
         step(0, (c % 12 == 0) && (c < 96), 0, 1);
      end
      chk("t2_count", 64'(got_q.size()), 64'(64));
      for (int i = 0; i < 64; i++) begin
         if (i < got_q.size()) begin
            chk("t2_data", 64'(got_q[i][DW-1:0]), 64'(32'h200 + (i / 8) * 16 + (i % 8)));
            chk("t2_last", 64'(got_q[i][DW]),     64'(i == 31 || i == 63));
         end
      end

      // Backpressure: m_tready low for 20 cycles from T+2.
      got_q.delete();
      acc_base = 32'h100;
      nre = 0;
      for (int c = 0; c <= 44; c++) begin
         step(0, c == 0, 0, !(c >= 2 && c < 22));
         if (out_re && c <= 21) begin
            chk("t3_a", 64'(out_a), 64'(nre));
            nre++;
         end
         if (c >= 1 && c <= 21) chk("t3_busy", 64'(out_busy), 64'(1));
         if (c >= 3 && c <= 21) begin
            chk("t3_vld",  64'(ax.m_tvalid), 64'(1));
            chk("t3_data", 64'(ax.m_tdata),  64'(32'h100));
         end
         if (c == 21) chk("t3_nre", 64'(nre), 64'(DEPTH));
      end
      chk_stream("t3", 8, 32'h100);
      chk("t3_outrf", 64'(outrf), 64'(1));

      // Alternating ready exercises push/pop at FIFO full and empty.
      got_q.delete();
      acc_base = 32'h300;
      for (int c = 0; c < 40; c++) step(0, c == 0, 0, (c % 2) == 1);
      chk_stream("t4", 8, 32'h300);
      chk("t4_outrf", 64'(outrf), 64'(1));

      // Reset mid-stream, then a clean restart.
      acc_base = 32'h100;
      for (int c = 0; c <= 24; c++) begin
         if (c == 7) begin
            got_q.delete();
            acc_base = 32'h400;
         end
         step(c == 5, c == 0 || c == 8, 0, 1);
         if (c == 6) begin
            chk("t5_vld",   64'(ax.m_tvalid), 64'(0));
            chk("t5_busy",  64'(out_busy),    64'(0));
            chk("t5_outrf", 64'(outrf),       64'(1));
            chk("t5_re",    64'(out_re),      64'(0));
         end
         if (c == 9) begin
            chk("t5_re2", 64'(out_re), 64'(1));
            chk("t5_a0",  64'(out_a),  64'(0));
         end
      end
      chk_stream("t5", 8, 32'h400);

      // Illegal second k_fin while reading.
      got_q.delete();
      acc_base = 32'h500;
      nre = 0;
      for (int c = 0; c <= 20; c++) begin
         step(0, c == 0 || c == 3, 0, 1);
         if (out_re) nre++;
         if (c == 2) chk("t6_err_pre", 64'(err), 64'(0));
         if (c == 4) chk("t6_err",     64'(err), 64'(ERR_EXP));
      end
      chk("t6_nre", 64'(nre), 64'(8));
      chk_stream("t6", 8, 32'h500);
      chk("t6_err_end", 64'(err), 64'(ERR_EXP));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
